// File: rtl/coremem_arbiter.sv
// Shares one single-port 1-cycle SRAM between data and fetch ports.
// Round-robin or data-first arbitration with a fetch starvation bound.
module coremem_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    input  logic          instr_req_i,
    input  logic [AW-1:0] instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          CE,
    output logic          WE,
    output logic [AW-1:0] mem_addr_o,
    output logic [3:0]    mem_be_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_DATA  = 2'd1,
        RESP_INSTR = 2'd2
    } resp_e;

    typedef enum logic {
        WIN_DATA  = 1'b0,
        WIN_INSTR = 1'b1
    } port_e;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    resp_e      resp_q, resp_d;
    port_e      last_q, last_d;
    logic [3:0] starve_q, starve_d;
    logic       data_pref;
    logic       data_win;
    logic       instr_win;

    // Which port takes a cycle when both are requesting
    always_comb begin
        data_pref = 1'b1;
        if (ARB_MODE == 0) begin
            data_pref = (last_q == WIN_INSTR);
        end else begin
            data_pref = (starve_q != SMAX);
        end
    end

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        data_win  = 1'b0;
        instr_win = 1'b0;
        if (rst_ni) begin
            unique case ({data_req_i, instr_req_i})
                2'b11: begin
                    data_win  = data_pref;
                    instr_win = ~data_pref;
                end
                2'b10:   data_win  = 1'b1;
                2'b01:   instr_win = 1'b1;
                default: ;
            endcase
        end
    end

    // SRAM strobes and request fields muxed from the winner
    always_comb begin
        CE          = data_win | instr_win;
        WE          = data_win & data_we_i;
        mem_addr_o  = instr_win ? instr_addr_i : data_addr_i;
        mem_be_o    = (data_win && data_we_i) ? data_be_i : 4'hF;
        mem_wdata_o = data_wdata_i;
    end

    assign data_gnt_o  = data_win;
    assign instr_gnt_o = instr_win;

    // Next response tag, round-robin history and starvation count
    always_comb begin
        resp_d = RESP_NONE;
        last_d = last_q;
        if (data_win) begin
            resp_d = RESP_DATA;
            last_d = WIN_DATA;
        end else if (instr_win) begin
            resp_d = RESP_INSTR;
            last_d = WIN_INSTR;
        end
        starve_d = 4'd0;
        if (instr_req_i && !instr_win) begin
            starve_d = (starve_q < SMAX) ? starve_q + 4'd1 : SMAX;
        end
    end

    // State registers; reset drops any response in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q   <= RESP_NONE;
            last_q   <= WIN_INSTR;
            starve_q <= 4'd0;
        end else begin
            resp_q   <= resp_d;
            last_q   <= last_d;
            starve_q <= starve_d;
        end
    end

    assign data_rvalid_o  = (resp_q == RESP_DATA);
    assign instr_rvalid_o = (resp_q == RESP_INSTR);
    assign data_rdata_o   = mem_rdata_i;
    assign instr_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_coremem_arbiter.sv
// Bench for coremem_arbiter: one instance per arbitration mode,
// each with its own SRAM and a transaction-level reference model.
module tb_coremem_arbiter;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        dreq  [2];
    logic        dwe   [2];
    logic [3:0]  dbe   [2];
    logic [15:0] daddr [2];
    logic [31:0] dwd   [2];
    logic        dgnt  [2];
    logic        drv   [2];
    logic [31:0] drd   [2];
    logic        ireq  [2];
    logic [15:0] iaddr [2];
    logic        ignt  [2];
    logic        irv   [2];
    logic [31:0] ird   [2];
    logic        ce    [2];
    logic        we    [2];
    logic [15:0] maddr [2];
    logic [3:0]  mbe   [2];
    logic [31:0] mwd   [2];
    logic [31:0] mrd   [2];

    coremem_arbiter #(
        .AW(16), .ARB_MODE(0), .STARVE_MAX(SMAX)
    ) dut0 (
        .clk_i(clk), .rst_ni(rstn),
        .data_req_i(dreq[0]), .data_we_i(dwe[0]),
        .data_be_i(dbe[0]), .data_addr_i(daddr[0]),
        .data_wdata_i(dwd[0]), .data_gnt_o(dgnt[0]),
        .data_rvalid_o(drv[0]), .data_rdata_o(drd[0]),
        .instr_req_i(ireq[0]), .instr_addr_i(iaddr[0]),
        .instr_gnt_o(ignt[0]), .instr_rvalid_o(irv[0]),
        .instr_rdata_o(ird[0]), .CE(ce[0]), .WE(we[0]),
        .mem_addr_o(maddr[0]), .mem_be_o(mbe[0]),
        .mem_wdata_o(mwd[0]), .mem_rdata_i(mrd[0])
    );

    coremem_arbiter #(
        .AW(16), .ARB_MODE(1), .STARVE_MAX(SMAX)
    ) dut1 (
        .clk_i(clk), .rst_ni(rstn),
        .data_req_i(dreq[1]), .data_we_i(dwe[1]),
        .data_be_i(dbe[1]), .data_addr_i(daddr[1]),
        .data_wdata_i(dwd[1]), .data_gnt_o(dgnt[1]),
        .data_rvalid_o(drv[1]), .data_rdata_o(drd[1]),
        .instr_req_i(ireq[1]), .instr_addr_i(iaddr[1]),
        .instr_gnt_o(ignt[1]), .instr_rvalid_o(irv[1]),
        .instr_rdata_o(ird[1]), .CE(ce[1]), .WE(we[1]),
        .mem_addr_o(maddr[1]), .mem_be_o(mbe[1]),
        .mem_wdata_o(mwd[1]), .mem_rdata_i(mrd[1])
    );

    // SRAM behaviour: byte-masked writes, registered reads
    logic [31:0] sram [2][256];
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < 256; a++)
                    sram[k][a] <= 32'hA5A5_0000 | 32'(a);
            mem_ready <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ce[k]) begin
                    if (we[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (mbe[k][b])
                                sram[k][maddr[k][7:0]][8*b +: 8]
                                    <= mwd[k][8*b +: 8];
                    end else begin
                        mrd[k] <= sram[k][maddr[k][7:0]];
                    end
                end
            end
        end
    end

    typedef struct {
        bit          dv;
        bit          we;
        logic [3:0]  be;
        logic [15:0] da;
        logic [31:0] wd;
        bit          iv;
        logic [15:0] ia;
    } req_t;

    req_t        rq [2];
    bit          hold;
    logic [31:0] shm [2][256];
    int          pend [2];
    bit          pend_rd [2];
    logic [31:0] pend_data [2];
    int          last [2];
    int          loss [2];
    int          lg [2][$];
    logic        snap_we [2];
    logic [3:0]  snap_be [2];
    logic [15:0] snap_addr [2];
    int          nchk = 0;
    int          nerr = 0;
    int          e0 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int          e1 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    task automatic chk(input int k, input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL i%0d %s: got %h expected %h @%0t",
                     k, nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus, prediction, comparison and model update.
    // Entered and left at posedge+1.
    task automatic cycle();
        bit wd [2];
        bit wi [2];
        for (int k = 0; k < 2; k++) begin
            dreq[k]  = rq[k].dv;
            dwe[k]   = rq[k].we;
            dbe[k]   = rq[k].be;
            daddr[k] = rq[k].da;
            dwd[k]   = rq[k].wd;
            ireq[k]  = rq[k].iv;
            iaddr[k] = rq[k].ia;
            wd[k] = 1'b0;
            wi[k] = 1'b0;
            if (!rstn) begin
                pend[k] = 0;
            end else if (rq[k].dv && rq[k].iv) begin
                if (k == 0) wd[k] = (last[k] == 1);
                else        wd[k] = (loss[k] != SMAX);
                wi[k] = !wd[k];
            end else begin
                wd[k] = rq[k].dv;
                wi[k] = rq[k].iv;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(k, "data_gnt", dgnt[k], wd[k]);
            chk(k, "instr_gnt", ignt[k], wi[k]);
            chk(k, "CE", ce[k], wd[k] | wi[k]);
            chk(k, "WE", we[k], wd[k] & rq[k].we);
            if (wd[k] | wi[k]) begin
                chk(k, "mem_addr", maddr[k],
                    wd[k] ? rq[k].da : rq[k].ia);
                chk(k, "mem_be", mbe[k],
                    (wd[k] && rq[k].we) ? rq[k].be : 4'hF);
            end
            if (wd[k] && rq[k].we)
                chk(k, "mem_wdata", mwd[k], rq[k].wd);
            chk(k, "data_rvalid", drv[k], pend[k] == 1);
            chk(k, "instr_rvalid", irv[k], pend[k] == 2);
            if (pend[k] != 0 && pend_rd[k]) begin
                chk(k, "data_rdata", drd[k], pend_data[k]);
                chk(k, "instr_rdata", ird[k], pend_data[k]);
            end
            snap_we[k]   = we[k];
            snap_be[k]   = mbe[k];
            snap_addr[k] = maddr[k];
        end
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                pend[k] = 0;
                last[k] = 1;
                loss[k] = 0;
            end else begin
                pend[k] = wd[k] ? 1 : (wi[k] ? 2 : 0);
                pend_rd[k] = wi[k] || (wd[k] && !rq[k].we);
                pend_data[k] = shm[k][wi[k] ? rq[k].ia[7:0]
                                            : rq[k].da[7:0]];
                if (wd[k] && rq[k].we)
                    for (int b = 0; b < 4; b++)
                        if (rq[k].be[b])
                            shm[k][rq[k].da[7:0]][8*b +: 8] =
                                rq[k].wd[8*b +: 8];
                if (wd[k]) last[k] = 0;
                else if (wi[k]) last[k] = 1;
                if (rq[k].iv && !wi[k])
                    loss[k] = (loss[k] < SMAX) ? loss[k] + 1 : loss[k];
                else
                    loss[k] = 0;
                if (wd[k]) lg[k].push_back(0);
                if (wi[k]) lg[k].push_back(1);
                if (wd[k] && !hold) rq[k].dv = 1'b0;
                if (wi[k] && !hold) rq[k].iv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [15:0] a, input bit w,
                         input logic [3:0] be, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            rq[k].dv = 1'b1;
            rq[k].we = w;
            rq[k].be = be;
            rq[k].da = a;
            rq[k].wd = d;
        end
    endtask

    task automatic clear_req();
        for (int k = 0; k < 2; k++) begin
            rq[k].dv = 1'b0;
            rq[k].iv = 1'b0;
        end
        hold = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        hold = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++)
                shm[k][a] = 32'hA5A5_0000 | 32'(a);
            rq[k] = '{1'b1, 1'b0, 4'hF, 16'h1, 32'h0, 1'b1, 16'h2};
            pend[k] = 0;
            pend_rd[k] = 1'b0;
            pend_data[k] = 32'h0;
            last[k] = 1;
            loss[k] = 0;
        end
        @(posedge clk);
        #1;
        cycle();
        cycle();
        for (int k = 0; k < 2; k++)
            chk(k, "reset_rvalid", {drv[k], irv[k]}, 2'b00);
        rstn = 1'b1;
        clear_req();
        cycle();

        set_d(16'h0010, 1'b0, 4'hF, 32'h0);
        cycle();
        chk(0, "rd_addr", snap_addr[0], 16'h0010);
        chk(0, "rd_we", snap_we[0], 1'b0);
        chk(0, "rd_rvalid", drv[0], 1'b1);
        chk(0, "rd_rdata", drd[0], 32'hA5A5_0010);

        set_d(16'h0010, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        cycle();
        chk(0, "wr_we", snap_we[0], 1'b1);
        chk(0, "wr_be", snap_be[0], 4'b0011);
        chk(0, "wr_rvalid", drv[0], 1'b1);
        set_d(16'h0010, 1'b0, 4'hF, 32'h0);
        cycle();
        chk(0, "rdback", drd[0], 32'hA5A5_BEEF);
        chk(1, "rdback", drd[1], 32'hA5A5_BEEF);

        set_d(16'h0020, 1'b0, 4'hF, 32'h0);
        cycle();
        chk(0, "pre_rst_rvalid", drv[0], 1'b1);
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++)
            chk(k, "rst_drop", {drv[k], irv[k]}, 2'b00);
        set_d(16'h0030, 1'b0, 4'hF, 32'h0);
        for (int k = 0; k < 2; k++) begin
            rq[k].iv = 1'b1;
            rq[k].ia = 16'h0005;
        end
        hold = 1'b1;
        cycle();
        rstn = 1'b1;
        for (int k = 0; k < 2; k++) lg[k].delete();
        for (int n = 0; n < 10; n++) cycle();
        chk(0, "contest_len", lg[0].size(), 10);
        chk(1, "contest_len", lg[1].size(), 10);
        for (int n = 0; n < 10 && n < lg[0].size(); n++)
            chk(0, $sformatf("rr_seq%0d", n), lg[0][n], e0[n]);
        for (int n = 0; n < 10 && n < lg[1].size(); n++)
            chk(1, $sformatf("dp_seq%0d", n), lg[1][n], e1[n]);
        clear_req();

        for (int k = 0; k < 2; k++) lg[k].delete();
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 2; k++) begin
                rq[k].iv = 1'b1;
                rq[k].ia = 16'(n);
            end
            cycle();
            chk(0, "stream_rv", irv[0], 1'b1);
            chk(0, "stream_word", ird[0], 32'hA5A5_0000 | 32'(n));
        end
        chk(0, "stream_gnts", lg[0].size(), 8);

        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < 2; k++) begin
                if (!rq[k].dv && $urandom_range(0, 2) != 0) begin
                    rq[k].dv = 1'b1;
                    rq[k].we = 1'($urandom_range(0, 1));
                    rq[k].be = 4'($urandom_range(0, 15));
                    rq[k].da = 16'($urandom_range(0, 63));
                    rq[k].wd = $urandom;
                end
                if (!rq[k].iv && $urandom_range(0, 2) != 0) begin
                    rq[k].iv = 1'b1;
                    rq[k].ia = 16'($urandom_range(0, 63));
                end
            end
            cycle();
        end
        rstn = 1'b1;
        clear_req();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
